// File: rtl/spike_rate_meter.sv
// spike_rate_meter: converts a spike train into per-window rate, inter-spike interval and burst flag.
// Counting only happens once en has been high for a full cycle (FSM out of IDLE).
module spike_rate_meter #(
    parameter int WIN_CYCLES = 1000,
    parameter int WIN_W      = 16,
    parameter int CNT_W      = 8,
    parameter int ISI_W      = 12,
    parameter int BURST_TH   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             spike,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid,
    output logic             burst,
    output logic [1:0]       fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TIMING = 2'd2} state_t;

    state_t           state, state_nx;
    logic             spike_q, spk_edge, run, close;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt, spk_sum;
    logic [ISI_W-1:0] isi_cnt;

    assign spk_edge  = spike & ~spike_q;
    assign run       = en && (state != IDLE);
    assign close     = run && (win_cnt == WIN_W'(WIN_CYCLES - 1));
    assign spk_sum   = (&spk_cnt) ? spk_cnt : spk_cnt + CNT_W'(spk_edge);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!en)                                  state_nx = IDLE;
        else if (state == IDLE)                   state_nx = ARMED;
        else if (state == TIMING || spk_edge)     state_nx = TIMING;
        else                                      state_nx = ARMED;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spike_q    <= 1'b0;
            win_cnt    <= '0;
            spk_cnt    <= '0;
            isi_cnt    <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            isi        <= '0;
            isi_valid  <= 1'b0;
            burst      <= 1'b0;
        end else begin
            spike_q    <= spike;
            rate_valid <= 1'b0;
            isi_valid  <= 1'b0;
            if (!run) begin
                win_cnt <= '0;
                spk_cnt <= '0;
                isi_cnt <= '0;
            end else begin
                win_cnt <= close ? '0 : win_cnt + WIN_W'(1);
                spk_cnt <= close ? '0 : spk_sum;
                if (close) begin
                    rate       <= spk_sum;
                    rate_valid <= 1'b1;
                    burst      <= spk_sum >= CNT_W'(BURST_TH);
                end
                if (state == TIMING && spk_edge) begin
                    isi       <= isi_cnt;
                    isi_valid <= 1'b1;
                end
                // ARMED waits at 0 for the first edge; TIMING counts up and sticks at all-ones
                isi_cnt <= spk_edge ? ISI_W'(1) :
                           (state == TIMING && !(&isi_cnt)) ? isi_cnt + ISI_W'(1) : isi_cnt;
            end
        end
    end
endmodule

// File: tb/tb_spike_rate_meter.sv
// tb_spike_rate_meter: directed and random stimulus against two meter instances (16- and 1024-cycle windows).
module tb_spike_rate_meter;
    logic       clk = 1'b0;
    logic       reset_n, en, spike;
    logic [7:0] rate_a, rate_b;
    logic [5:0] isi_a, isi_b;
    logic       rv_a, rv_b, iv_a, iv_b, burst_a, burst_b;
    logic [1:0] fsm_a, fsm_b;

    int checks = 0, failures = 0;

    int t = 0, act_n = 0, a_cnt = 0, b_cnt = 0, last_edge = -1;
    bit last_en = 0, prev_spk = 0;
    int e_rate_a = 0, e_rv_a = 0, e_burst_a = 0, e_rate_b = 0, e_rv_b = 0, e_burst_b = 0;
    int e_isi = 0, e_iv = 0, e_fsm = 0;

    always #5 clk = ~clk;

    spike_rate_meter #(.WIN_CYCLES(16), .WIN_W(8), .CNT_W(8), .ISI_W(6), .BURST_TH(4)) da (
        .clk(clk), .reset_n(reset_n), .en(en), .spike(spike),
        .rate(rate_a), .rate_valid(rv_a), .isi(isi_a), .isi_valid(iv_a),
        .burst(burst_a), .fsm_state(fsm_a));

    spike_rate_meter #(.WIN_CYCLES(1024), .WIN_W(11), .CNT_W(8), .ISI_W(6), .BURST_TH(4)) db (
        .clk(clk), .reset_n(reset_n), .en(en), .spike(spike),
        .rate(rate_b), .rate_valid(rv_b), .isi(isi_b), .isi_valid(iv_b),
        .burst(burst_b), .fsm_state(fsm_b));

    function automatic int min_i(int a, int b);
        return a < b ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    // Model: counts active cycles since enable and edge times; window = act_n / WIN.
    task automatic step(input bit rn, input bit e, input bit s);
        bit ed;
        reset_n = rn; en = e; spike = s;
        @(posedge clk);
        if (!rn) begin
            e_rate_a = 0; e_rv_a = 0; e_burst_a = 0; e_rate_b = 0; e_rv_b = 0; e_burst_b = 0;
            e_isi = 0; e_iv = 0; e_fsm = 0;
            last_en = 0; prev_spk = 0; act_n = 0; a_cnt = 0; b_cnt = 0; last_edge = -1;
        end else begin
            ed = s && !prev_spk;
            prev_spk = s;
            e_rv_a = 0; e_rv_b = 0; e_iv = 0;
            if (e && last_en) begin
                a_cnt += int'(ed);
                b_cnt += int'(ed);
                if (act_n % 16 == 15) begin
                    e_rate_a = min_i(a_cnt, 255); e_rv_a = 1; e_burst_a = int'(e_rate_a >= 4); a_cnt = 0;
                end
                if (act_n % 1024 == 1023) begin
                    e_rate_b = min_i(b_cnt, 255); e_rv_b = 1; e_burst_b = int'(e_rate_b >= 4); b_cnt = 0;
                end
                if (ed) begin
                    if (last_edge >= 0) begin
                        e_isi = min_i(t - last_edge, 63);
                        e_iv = 1;
                    end
                    last_edge = t;
                end
                act_n++;
            end else begin
                act_n = 0; a_cnt = 0; b_cnt = 0; last_edge = -1;
            end
            e_fsm = !e ? 0 : (!last_en ? 1 : (last_edge >= 0 ? 2 : 1));
            last_en = e;
        end
        t++;
        #1;
        chk("rate_a", rate_a, e_rate_a);
        chk("rate_valid_a", rv_a, e_rv_a);
        chk("burst_a", burst_a, e_burst_a);
        chk("isi_a", isi_a, e_isi);
        chk("isi_valid_a", iv_a, e_iv);
        chk("fsm_a", fsm_a, e_fsm);
        chk("rate_b", rate_b, e_rate_b);
        chk("rate_valid_b", rv_b, e_rv_b);
        chk("burst_b", burst_b, e_burst_b);
        chk("isi_b", isi_b, e_isi);
        chk("fsm_b", fsm_b, e_fsm);
    endtask

    task automatic win(input logic [15:0] pat);
        for (int i = 0; i < 16; i++) step(1, 1, pat[i]);
    endtask

    initial begin
        int saved;
        bit r, e, s;
        step(0, 0, 1);
        step(0, 0, 1);
        chk("reset_rate", rate_a, 0);
        chk("reset_isi", isi_a, 0);
        chk("reset_fsm", fsm_a, 0);
        chk("reset_burst", burst_a, 0);
        repeat (3) step(1, 0, 0);

        step(1, 1, 0);
        win(16'h8084);
        chk("rate3", rate_a, 3);
        chk("rate3_valid", rv_a, 1);
        chk("rate3_burst", burst_a, 0);
        win(16'h02AA);
        chk("rate5", rate_a, 5);
        chk("rate5_burst", burst_a, 1);

        win(16'h0FC0);
        chk("long_spike", rate_a, 1);
        win(16'hE000);
        chk("cross_early", rate_a, 1);
        win(16'h0007);
        chk("cross_late", rate_a, 0);
        chk("cross_burst", burst_a, 0);

        step(1, 0, 0);
        step(1, 0, 0);
        chk("drop_fsm", fsm_a, 0);
        step(1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, i == 10 || i == 17 || i == 19);
            if (i == 10) chk("isi_first_nopulse", iv_a, 0);
            if (i == 17) begin chk("isi7", isi_a, 7); chk("isi7_valid", iv_a, 1); end
            if (i == 19) begin chk("isi2", isi_a, 2); chk("isi2_valid", iv_a, 1); end
        end

        for (int i = 0; i < 120; i++) begin
            step(1, 1, i == 0 || i == 100);
            if (i == 100) chk("isi_sat", isi_a, 63);
        end

        step(1, 0, 0);
        step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, i == 1 || i == 3);
        saved = e_rate_a;
        step(1, 0, 0);
        chk("drop_nvalid", rv_a, 0);
        chk("drop_keep", rate_a, saved);
        chk("drop_fsm0", fsm_a, 0);

        step(1, 1, 0);
        for (int i = 0; i < 1024; i++) step(1, 1, i[0]);
        chk("rate_sat", rate_b, 255);
        chk("rate_sat_valid", rv_b, 1);

        s = 0;
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(299) != 0);
            e = ($urandom_range(39) != 0);
            if ($urandom_range(2) == 0) s = ~s;
            step(r, e, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
